write_stream: RTL and testbench

// - Successor of the clip-and-write stage: buffers GROUP_SIZE-wide results from the upstream pipeline and writes them to a block RAM.
// - Adds a run FSM with a write count, strided auto-incremented addresses, a downstream ready, signed clipping with optional ReLU, done/busy status and overflow detection.
// - Sits between the last compute stage and the output block RAM / write arbiter.

---
 rtl/write_stream_pkg.sv | 39 +++
 rtl/write_stream_fifo.sv | 57 +++++
 rtl/write_stream.sv | 156 +++++++++++++++
 tb/tb_write_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/write_stream_pkg.sv
// rtl/write_stream_pkg.sv - shared FSM encoding and per-element clip helper for write_stream
package write_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CLIP_W = 32;

   // Operands arrive pre-extended to CLIP_W, so this compare matches one done at the element width.
   function automatic logic [CLIP_W-1:0] clip_elem(
      input logic [CLIP_W-1:0] x,
      input logic [CLIP_W-1:0] min_v,
      input logic [CLIP_W-1:0] max_v,
      input logic              is_signed,
      input logic              relu
   );
      logic [CLIP_W-1:0] v;
      logic              gt;
      logic              lt;
      v = (relu && is_signed && x[CLIP_W-1]) ? '0 : x;
      if (is_signed) begin
         gt = $signed(v) > $signed(max_v);
         lt = $signed(v) < $signed(min_v);
      end else begin
         gt = v > max_v;
         lt = v < min_v;
      end
      if (gt)
         return max_v;
      else if (lt)
         return min_v;
      else
         return v;
   endfunction

endpackage

// File: rtl/write_stream_fifo.sv
// rtl/write_stream_fifo.sv - registered FIFO with full/empty flags and free-slot count
module write_stream_fifo
   import write_stream_pkg::*;
#(
   parameter int LOG_DEPTH = 2,
   parameter int WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_data,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_data,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [LOG_DEPTH:0]   o_free
);
   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [LOG_DEPTH-1:0] r_wr_ptr;
   logic [LOG_DEPTH-1:0] r_rd_ptr;
   logic [LOG_DEPTH:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_full  = (r_count == (LOG_DEPTH+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_free  = (LOG_DEPTH+1)'(DEPTH) - r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
            2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/write_stream.sv
// rtl/write_stream.sv - buffers upstream beats, clips each element and writes them to RAM
// at strided addresses under a run FSM with done/busy/overflow status.
module write_stream
   import write_stream_pkg::*;
#(
   parameter int GROUP_SIZE      = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int OUT_WIDTH       = 4,
   parameter int LOG_MAX_ADDRESS = 16,
   parameter int LOG_MAX_WRITES  = 16,
   parameter int LOG_FIFO_DEPTH  = 2,
   parameter int SIGNED_DATA     = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             configure,
   input  logic [LOG_MAX_ADDRESS-1:0]       base_address,
   input  logic [LOG_MAX_ADDRESS-1:0]       address_stride,
   input  logic [LOG_MAX_WRITES-1:0]        num_writes,
   input  logic [OUT_WIDTH-1:0]             min_clip,
   input  logic [OUT_WIDTH-1:0]             max_clip,
   input  logic                             relu_en,
   input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
   input  logic                             valid_in,
   output logic                             avail_out,
   input  logic                             ready_in,
   output logic [GROUP_SIZE*OUT_WIDTH-1:0]  data_out,
   output logic [LOG_MAX_ADDRESS-1:0]       address_out,
   output logic                             valid_out,
   output logic                             busy,
   output logic                             done,
   output logic                             overflow
);
   state_t                            r_state;
   state_t                            w_next_state;
   logic [LOG_MAX_ADDRESS-1:0]        r_addr;
   logic [LOG_MAX_ADDRESS-1:0]        r_stride;
   logic [LOG_MAX_WRITES-1:0]         r_remaining;
   logic [OUT_WIDTH-1:0]              r_min;
   logic [OUT_WIDTH-1:0]              r_max;
   logic                              r_relu;
   logic                              r_overflow;
   logic                              w_full;
   logic                              w_empty;
   logic [LOG_FIFO_DEPTH:0]           w_free;
   logic [GROUP_SIZE*DATA_WIDTH-1:0]  w_head;
   logic [GROUP_SIZE*OUT_WIDTH-1:0]   w_clipped;
   logic                              w_load;
   logic                              w_accept;
   logic                              w_last;

   write_stream_fifo #(
      .LOG_DEPTH (LOG_FIFO_DEPTH),
      .WIDTH     (GROUP_SIZE*DATA_WIDTH)
   ) fifo_in (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (valid_in),
      .i_data  (data_in),
      .i_pop   (w_accept),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_free  (w_free)
   );

   assign w_load   = configure & (r_state != ST_RUN);
   assign w_accept = valid_out & ready_in;
   assign w_last   = w_accept & (r_remaining == LOG_MAX_WRITES'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (configure)
               w_next_state = (num_writes == '0) ? ST_DONE : ST_RUN;
            else if (r_state == ST_DONE)
               w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (w_last)
               w_next_state = ST_DONE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      valid_out = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         ST_RUN: begin
            busy      = 1'b1;
            valid_out = ~w_empty;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_stride    <= '0;
         r_remaining <= '0;
         r_min       <= '0;
         r_max       <= '0;
         r_relu      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_load) begin
            r_addr      <= base_address;
            r_stride    <= address_stride;
            r_remaining <= num_writes;
            r_min       <= min_clip;
            r_max       <= max_clip;
            r_relu      <= relu_en;
         end else if (w_accept) begin
            r_addr      <= r_addr + r_stride;
            r_remaining <= r_remaining - LOG_MAX_WRITES'(1);
         end
         // A beat dropped in the configure cycle itself still flags, so that run starts already overflowed.
         if (valid_in & w_full)
            r_overflow <= 1'b1;
         else if (w_load)
            r_overflow <= 1'b0;
      end
   end

   for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_clip
      logic [DATA_WIDTH-1:0] w_elem;
      logic [CLIP_W-1:0]     w_x;
      logic [CLIP_W-1:0]     w_lo;
      logic [CLIP_W-1:0]     w_hi;
      assign w_elem = w_head[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_x    = {{(CLIP_W-DATA_WIDTH){(SIGNED_DATA != 0) && w_elem[DATA_WIDTH-1]}}, w_elem};
      assign w_lo   = {{(CLIP_W-OUT_WIDTH){(SIGNED_DATA != 0) && r_min[OUT_WIDTH-1]}}, r_min};
      assign w_hi   = {{(CLIP_W-OUT_WIDTH){(SIGNED_DATA != 0) && r_max[OUT_WIDTH-1]}}, r_max};
      assign w_clipped[g*OUT_WIDTH +: OUT_WIDTH] =
         OUT_WIDTH'(clip_elem(w_x, w_lo, w_hi, SIGNED_DATA != 0, r_relu));
   end

   assign data_out    = valid_out ? w_clipped : '0;
   assign address_out = r_addr;
   assign avail_out   = (w_free >= (LOG_FIFO_DEPTH+1)'(2));
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_write_stream.sv
// tb/tb_write_stream.sv - directed-vector bench for write_stream
module tb_write_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic        configure;
   logic [15:0] base_address;
   logic [15:0] address_stride;
   logic [15:0] num_writes;
   logic [3:0]  min_clip;
   logic [3:0]  max_clip;
   logic        relu_en;
   logic [31:0] data_in;
   logic        valid_in;
   logic        avail_out;
   logic        ready_in;
   logic [15:0] data_out;
   logic [15:0] address_out;
   logic        valid_out;
   logic        busy;
   logic        done;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] wr_addr [$];
   logic [15:0] wr_data [$];

   write_stream dut (
      .clk            (clk),
      .rst            (rst),
      .configure      (configure),
      .base_address   (base_address),
      .address_stride (address_stride),
      .num_writes     (num_writes),
      .min_clip       (min_clip),
      .max_clip       (max_clip),
      .relu_en        (relu_en),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .avail_out      (avail_out),
      .ready_in       (ready_in),
      .data_out       (data_out),
      .address_out    (address_out),
      .valid_out      (valid_out),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && valid_out && ready_in) begin
         wr_addr.push_back(address_out);
         wr_data.push_back(data_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] beat(input int e0, input int e1, input int e2, input int e3);
      return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   task automatic start_run(input logic [15:0] b, input logic [15:0] s, input logic [15:0] n,
                            input logic [3:0] lo, input logic [3:0] hi, input logic r);
      base_address   = b;
      address_stride = s;
      num_writes     = n;
      min_clip       = lo;
      max_clip       = hi;
      relu_en        = r;
      configure      = 1'b1;
      tick();
      configure      = 1'b0;
   endtask

   task automatic push_beat(input logic [31:0] d);
      data_in  = d;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int k = 0;
      while (!done && k < limit) begin
         tick();
         k++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      tick();
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
      chk({tag, "_addr"}, (idx < wr_addr.size()) ? 32'(wr_addr[idx]) : 32'hFFFF_FFFF, 32'(a));
      chk({tag, "_data"}, (idx < wr_data.size()) ? 32'(wr_data[idx]) : 32'hFFFF_FFFF, 32'(d));
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   initial begin
      logic [15:0] exp_a [4];
      logic [15:0] exp_d [4];

      rst = 1'b0; configure = 1'b0; base_address = '0; address_stride = '0; num_writes = '0;
      min_clip = '0; max_clip = '0; relu_en = 1'b0; data_in = '0; valid_in = 1'b0; ready_in = 1'b0;
      tick(); tick();
      chk("rst_valid_out", 32'(valid_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_address", 32'(address_out), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_avail", 32'(avail_out), 1);
      rst = 1'b1;
      tick();

      // basic run
      clear_log();
      ready_in = 1'b1;
      start_run(16'h0010, 16'd1, 16'd3, 4'd0, 4'd7, 1'b0);
      chk("basic_busy", 32'(busy), 1);
      for (int i = 0; i < 3; i++) push_beat(beat(9, 3, -2, 7));
      wait_done("basic", 20);
      chk("basic_count", wr_addr.size(), 3);
      for (int i = 0; i < 3; i++) chk_wr("basic", i, 16'h0010 + 16'(i), 16'h7037);

      // backpressure
      clear_log();
      ready_in = 1'b0;
      start_run(16'h0020, 16'd2, 16'd4, 4'd0, 4'd7, 1'b0);
      push_beat(beat(1, 2, 3, 4));
      chk("bp_valid_first", 32'(valid_out), 1);
      chk("bp_avail_free3", 32'(avail_out), 1);
      push_beat(beat(8, 0, 5, 6));
      chk("bp_avail_free2", 32'(avail_out), 1);
      push_beat(beat(-1, 7, 127, -128));
      chk("bp_avail_free1", 32'(avail_out), 0);
      push_beat(beat(2, 2, 2, 2));
      chk("bp_avail_free0", 32'(avail_out), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", 32'(valid_out), 1);
         chk("bp_hold_addr", 32'(address_out), 32'h0020);
         chk("bp_hold_data", 32'(data_out), 32'h4321);
      end
      chk("bp_no_overflow", 32'(overflow), 0);
      chk("bp_no_writes", wr_addr.size(), 0);
      ready_in = 1'b1;
      wait_done("bp", 20);
      exp_d = '{16'h4321, 16'h6507, 16'h0770, 16'h2222};
      chk("bp_count", wr_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk_wr("bp", i, 16'h0020 + 16'(2 * i), exp_d[i]);

      // stride with address wrap
      clear_log();
      start_run(16'hFFFE, 16'd3, 16'd3, 4'd0, 4'd7, 1'b0);
      for (int i = 0; i < 3; i++) push_beat(beat(1, 1, 1, 1));
      wait_done("wrap", 20);
      exp_a = '{16'hFFFE, 16'h0001, 16'h0004, 16'h0000};
      chk("wrap_count", wr_addr.size(), 3);
      for (int i = 0; i < 3; i++) chk_wr("wrap", i, exp_a[i], 16'h1111);

      // ReLU on, then off, with min=-4 max=5
      clear_log();
      start_run(16'h0030, 16'd1, 16'd1, 4'hC, 4'h5, 1'b1);
      push_beat(beat(-3, 6, 2, -8));
      wait_done("relu_on", 20);
      chk_wr("relu_on", 0, 16'h0030, 16'h0250);
      clear_log();
      start_run(16'h0031, 16'd1, 16'd1, 4'hC, 4'h5, 1'b0);
      push_beat(beat(-3, 6, 2, -8));
      wait_done("relu_off", 20);
      chk_wr("relu_off", 0, 16'h0031, 16'hC25D);

      // zero-length run
      clear_log();
      start_run(16'h0035, 16'd1, 16'd0, 4'd0, 4'd7, 1'b0);
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_valid", 32'(valid_out), 0);
      tick();
      chk("zero_done_clear", 32'(done), 0);
      chk("zero_no_writes", wr_addr.size(), 0);

      // overflow while idle, then drained by the next run
      clear_log();
      ready_in = 1'b0;
      for (int i = 1; i <= 6; i++) push_beat(beat(i, i, i, i));
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_idle_valid", 32'(valid_out), 0);
      chk("ovf_avail", 32'(avail_out), 0);
      ready_in = 1'b1;
      start_run(16'h0040, 16'd1, 16'd4, 4'd0, 4'd7, 1'b0);
      chk("ovf_cleared", 32'(overflow), 0);
      wait_done("ovf", 20);
      exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      chk("ovf_count", wr_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk_wr("ovf", i, 16'h0040 + 16'(i), exp_d[i]);

      // asynchronous reset in the middle of a run
      clear_log();
      ready_in = 1'b0;
      start_run(16'h0050, 16'd1, 16'd4, 4'd0, 4'd7, 1'b0);
      push_beat(beat(5, 5, 5, 5));
      push_beat(beat(6, 6, 6, 6));
      chk("mid_valid", 32'(valid_out), 1);
      chk("mid_busy", 32'(busy), 1);
      chk("mid_addr", 32'(address_out), 32'h0050);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_out), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_addr", 32'(address_out), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      ready_in = 1'b1;
      start_run(16'h0060, 16'd1, 16'd1, 4'd0, 4'd7, 1'b0);
      tick(); tick(); tick();
      chk("post_rst_empty_valid", 32'(valid_out), 0);
      chk("post_rst_busy", 32'(busy), 1);
      chk("post_rst_avail", 32'(avail_out), 1);
      chk("post_rst_no_writes", wr_addr.size(), 0);
      push_beat(beat(3, 3, 3, 3));
      wait_done("post_rst", 20);
      chk("post_rst_count", wr_addr.size(), 1);
      chk_wr("post_rst", 0, 16'h0060, 16'h3333);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
